button_click_ctrl: RTL

BUTTON_CLICK_CTRL -- requirements
Module: button_click_ctrl

---
 rtl/snake_pkg.sv | 36 +++
 rtl/button_click_ctrl_debounce.sv | 42 ++++
 rtl/button_click_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared types and button geometry, so the hit area and the drawn rectangle
// use the same constants.
package snake_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        FIRE     = 2'd2,
        WAIT_REL = 2'd3
    } button_state_t;

    localparam int BTN_X   = 300;
    localparam int BTN_Y   = 400;
    localparam int BTN_W   = 200;
    localparam int BTN_H   = 60;
    localparam int COORD_W = 12;

    // Extending everything to 13 bits keeps right and bottom edges from wrapping.
    function automatic logic in_rect(input logic [COORD_W-1:0] x,
                                     input logic [COORD_W-1:0] y,
                                     input logic [COORD_W:0]   x0,
                                     input logic [COORD_W:0]   y0,
                                     input logic [COORD_W:0]   w,
                                     input logic [COORD_W:0]   h);
        logic [COORD_W:0] xe;
        logic [COORD_W:0] ye;
        logic [COORD_W:0] x1;
        logic [COORD_W:0] y1;
        xe = {1'b0, x};
        ye = {1'b0, y};
        x1 = x0 + w;
        y1 = y0 + h;
        return (xe >= x0) && (xe < x1) && (ye >= y0) && (ye < y1);
    endfunction

endpackage

// File: rtl/button_click_ctrl_debounce.sv
// Level debouncer: output follows the input only after it has differed for
// CYCLES consecutive clocks.
module debounce #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CW = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          dout_q, dout_d;

    always_comb begin
        cnt_d  = cnt_q;
        dout_d = dout_q;
        if (din == dout_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(CYCLES - 1)) begin
            dout_d = din;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            dout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/button_click_ctrl.sv
// On-screen button: hover and single-cycle click from a frame-latched cursor.
// Optional BUTTON_DEBOUNCE_EN debounces the raw left-button level.
module button_click_ctrl
    import snake_pkg::*;
#(
    parameter int X               = BTN_X,
    parameter int Y               = BTN_Y,
    parameter int W               = BTN_W,
    parameter int H               = BTN_H,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [COORD_W-1:0] mouse_x,
    input  logic [COORD_W-1:0] mouse_y,
    input  logic               mouse_left,
    input  logic               vblnk,
    output logic               hover,
    output logic               click
);

    localparam logic [COORD_W:0] X0 = (COORD_W + 1)'(X);
    localparam logic [COORD_W:0] Y0 = (COORD_W + 1)'(Y);
    localparam logic [COORD_W:0] WW = (COORD_W + 1)'(W);
    localparam logic [COORD_W:0] HH = (COORD_W + 1)'(H);

    logic               vblnk_q, vblnk_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               hit_q, hit_d;
    logic               hover_q, hover_d;
    logic               en_q, en_d;
    logic               hit;
    logic               p;
    button_state_t      state_q, state_d;

`ifdef BUTTON_DEBOUNCE_EN
    debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .din  (mouse_left),
        .dout (p)
    );
`else
    logic p_q, p_d;
    assign p_d = mouse_left;
    always_ff @(posedge clk) begin
        if (rst) p_q <= 1'b0;
        else     p_q <= p_d;
    end
    assign p = p_q;
`endif

    assign hit = in_rect(x_q, y_q, X0, Y0, WW, HH);

    // Coordinates only move on the vblank rising edge, matching the drawn frame.
    always_comb begin
        vblnk_d = vblnk;
        x_d     = x_q;
        y_d     = y_q;
        if (vblnk && !vblnk_q) begin
            x_d = mouse_x;
            y_d = mouse_y;
        end
        hit_d   = hit;
        hover_d = hit && en;
        en_d    = en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            hit_q   <= 1'b0;
            hover_q <= 1'b0;
            en_q    <= 1'b0;
            state_q <= IDLE;
        end else begin
            vblnk_q <= vblnk_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hit_q   <= hit_d;
            hover_q <= hover_d;
            en_q    <= en_d;
            state_q <= state_d;
        end
    end

    // A press already held when the screen goes live must not become a click.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else if (!en_q && p) begin
            state_d = WAIT_REL;
        end else begin
            unique case (state_q)
                IDLE:     if (p)  state_d = hit_q ? ARMED : WAIT_REL;
                ARMED:    if (!p) state_d = hit_q ? FIRE : IDLE;
                FIRE:     state_d = IDLE;
                WAIT_REL: if (!p) state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        click = (state_q == FIRE) && en;
        hover = hover_q && en;
    end

endmodule
